// File: rtl/sel_reg_arb_pkg.sv
// Shared types and helpers for the sel_reg_arb select register.
// Channel vectors are zero-extended to MAX_N bits before being handed to the helpers.
package sel_reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_N = 64;
  localparam int PC_W  = $clog2(MAX_N) + 1;

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_N-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [31:0] idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/sel_reg_arb_rr_pick.sv
// Rotate-priority picker: the first asserted request at or after start wins.
// It returns a one-hot grant (all-zero when idle) and the winner's binary index.
module rr_pick
  import sel_reg_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  // Scan the rotated order backwards so the earliest hit is the last assignment.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N]) idx = IW'((int'(start) + k) % N);
    end
    gnt = (|req) ? N'(onehot(32'(idx))) : '0;
  end

endmodule

// File: rtl/sel_reg_arb.sv
// N-channel shared register with fixed-priority or round-robin arbitration.
// Optional SEL_REG_ARB_SVA_EN compiles in the concurrent property checks.
module sel_reg_arb
  import sel_reg_arb_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     sel,
  input  logic [N*W-1:0]   d,
  output logic [W-1:0]     q,
  output logic             q_valid,
  output logic [N-1:0]     grant,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);
  localparam int IW = $clog2(N);

  logic [N-1:0]     pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             any_req;
  logic             multi_req;
  logic [W-1:0]     q_reg;
  logic             q_valid_reg;
  logic [N-1:0]     grant_reg;
  logic             conflict_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign any_req   = |sel;
  assign multi_req = popcount(MAX_N'(sel)) >= PC_W'(2);

  if (MODE == int'(ARB_RR)) begin : g_rr
    logic [IW-1:0] ptr_reg;

    rr_pick #(.N(N)) u_pick (
      .req   (sel),
      .start (ptr_reg),
      .gnt   (pick_gnt),
      .idx   (pick_idx)
    );

    // Next search starts just past the winner, wrapping for non-power-of-two N.
    always_ff @(posedge clk) begin
      if (rst) ptr_reg <= '0;
      else if (any_req) ptr_reg <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
    end
  end else begin : g_fixed
    always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N; i++) begin
        if (sel[i]) pick_idx = IW'(i);
      end
    end
    assign pick_gnt = any_req ? N'(onehot(32'(pick_idx))) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg        <= '0;
      q_valid_reg  <= 1'b0;
      grant_reg    <= '0;
      conflict_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      if (any_req) begin
        q_reg       <= d[pick_idx*W +: W];
        q_valid_reg <= 1'b1;
      end
      grant_reg    <= pick_gnt;
      conflict_reg <= multi_req;
      if (multi_req && (cnt_reg != {CNT_W{1'b1}})) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign q            = q_reg;
  assign q_valid      = q_valid_reg;
  assign grant        = grant_reg;
  assign conflict     = conflict_reg;
  assign conflict_cnt = cnt_reg;

`ifdef SEL_REG_ARB_SVA_EN
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_idle_hold: assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && !$past(|sel)) |-> $stable(q));
  a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
    !$past(rst) |-> conflict_cnt >= $past(conflict_cnt));
  a_cnt_sat: assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && $past(conflict_cnt) == {CNT_W{1'b1}}) |-> conflict_cnt == {CNT_W{1'b1}});

  for (genvar gi = 0; gi < N; gi++) begin : g_sva_ch
    a_data: assert property (@(posedge clk) disable iff (rst)
      grant[gi] |-> q == $past(d[gi*W +: W]));
    if (MODE == int'(ARB_FIXED)) begin : g_fixed_chk
      a_fixed_win: assert property (@(posedge clk) disable iff (rst)
        (sel[gi] && ((sel >> (gi + 1)) == '0)) |=> grant[gi]);
    end else begin : g_rr_chk
      localparam int SW = $clog2(N + 1) + 1;
      logic [SW-1:0] starve_reg;
      // Consecutive cycles this channel asked and lost.
      always_ff @(posedge clk) begin
        if (rst || !sel[gi] || pick_gnt[gi]) starve_reg <= '0;
        else starve_reg <= starve_reg + SW'(1);
      end
      a_no_starve: assert property (@(posedge clk) disable iff (rst) starve_reg < SW'(N));
    end
  end
`endif

endmodule

// File: tb/tb_sel_reg_arb.sv
// Directed bench: three sel_reg_arb instances (fixed, round-robin, fixed with a
// 2-bit conflict counter) share the same stimulus and are checked each cycle.
module tb_sel_reg_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sel = '0;
  logic [31:0] d   = '0;

  logic [7:0] q0, q1, q2;
  logic       v0, v1, v2;
  logic [3:0] g0, g1, g2;
  logic       c0, c1, c2;
  logic [7:0] n0, n1;
  logic [1:0] n2;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sel_reg_arb #(.W(8), .N(4), .MODE(0), .CNT_W(8)) u_fix (
    .clk(clk), .rst(rst), .sel(sel), .d(d),
    .q(q0), .q_valid(v0), .grant(g0), .conflict(c0), .conflict_cnt(n0));

  sel_reg_arb #(.W(8), .N(4), .MODE(1), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .sel(sel), .d(d),
    .q(q1), .q_valid(v1), .grant(g1), .conflict(c1), .conflict_cnt(n1));

  sel_reg_arb #(.W(8), .N(4), .MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .sel(sel), .d(d),
    .q(q2), .q_valid(v2), .grant(g2), .conflict(c2), .conflict_cnt(n2));

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b sel=%b d=%h | fix q=%h g=%b c=%b n=%0d | rr q=%h g=%b n=%0d | sat n=%0d",
             $time, rst, sel, d, q0, g0, c0, n0, q1, g1, n1, n2);
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 4'b1111; d = 32'hFFFF_FFFF;
    tick(); tick();
    ncmp++; if (q0 !== 8'h00) begin nfail++; $display("FAIL rst_q0 got %h want 00", q0); end
    ncmp++; if (v0 !== 1'b0) begin nfail++; $display("FAIL rst_v0 got %b want 0", v0); end
    ncmp++; if (g0 !== 4'b0000) begin nfail++; $display("FAIL rst_g0 got %b want 0000", g0); end
    ncmp++; if (c0 !== 1'b0) begin nfail++; $display("FAIL rst_c0 got %b want 0", c0); end
    ncmp++; if (n0 !== 8'd0) begin nfail++; $display("FAIL rst_n0 got %0d want 0", n0); end
    ncmp++; if ({q1, v1, g1, c1, n1} !== 22'd0) begin nfail++; $display("FAIL rst_rr got %h want 0", {q1, v1, g1, c1, n1}); end
    ncmp++; if ({q2, v2, g2, c2, n2} !== 16'd0) begin nfail++; $display("FAIL rst_sat got %h want 0", {q2, v2, g2, c2, n2}); end
    rst = 1'b0; sel = 4'b0000;
  endtask

  task automatic test_out_of_reset();
    sel = 4'b0000; d = 32'h1234_5678;
    tick();
    ncmp++; if (v0 !== 1'b0) begin nfail++; $display("FAIL oor_idle_v got %b want 0", v0); end
    ncmp++; if (q0 !== 8'h00) begin nfail++; $display("FAIL oor_idle_q got %h want 00", q0); end
    sel = 4'b1000; d = 32'h5A_77_66_55;
    tick();
    ncmp++; if (v0 !== 1'b1) begin nfail++; $display("FAIL oor_v got %b want 1", v0); end
    ncmp++; if (q0 !== 8'h5A) begin nfail++; $display("FAIL oor_q got %h want 5a", q0); end
    ncmp++; if (g0 !== 4'b1000) begin nfail++; $display("FAIL oor_g got %b want 1000", g0); end
    ncmp++; if (g1 !== 4'b1000 || q1 !== 8'h5A) begin nfail++; $display("FAIL oor_rr got g=%b q=%h want g=1000 q=5a", g1, q1); end
    ncmp++; if (c0 !== 1'b0) begin nfail++; $display("FAIL oor_c got %b want 0", c0); end
  endtask

  // rr pointer is 0 here (channel 3 last won), so round-robin picks channel 0.
  task automatic test_fixed_conflict();
    sel = 4'b0101; d = {8'h77, 8'hA5, 8'hEE, 8'h11};
    tick();
    ncmp++; if (q0 !== 8'hA5) begin nfail++; $display("FAIL fix_q got %h want a5", q0); end
    ncmp++; if (g0 !== 4'b0100) begin nfail++; $display("FAIL fix_g got %b want 0100", g0); end
    ncmp++; if (c0 !== 1'b1) begin nfail++; $display("FAIL fix_c got %b want 1", c0); end
    ncmp++; if (n0 !== 8'd1) begin nfail++; $display("FAIL fix_n got %0d want 1", n0); end
    ncmp++; if (g1 !== 4'b0001 || q1 !== 8'h11) begin nfail++; $display("FAIL fix_rr got g=%b q=%h want g=0001 q=11", g1, q1); end
    ncmp++; if (n2 !== 2'd1) begin nfail++; $display("FAIL fix_sat_n got %0d want 1", n2); end
  endtask

  task automatic test_idle_hold();
    sel = 4'b0001; d = {8'hAA, 8'hBB, 8'hCC, 8'h3C};
    tick();
    ncmp++; if (q0 !== 8'h3C) begin nfail++; $display("FAIL idle_wr got %h want 3c", q0); end
    for (int k = 0; k < 5; k++) begin
      sel = 4'b0000; d = 32'hDEAD_BEEF ^ (32'h0101_0101 * k);
      tick();
      ncmp++; if (q0 !== 8'h3C || q1 !== 8'h3C) begin nfail++; $display("FAIL idle_q%0d got %h/%h want 3c", k, q0, q1); end
      ncmp++; if (g0 !== 4'b0000 || g1 !== 4'b0000) begin nfail++; $display("FAIL idle_g%0d got %b/%b want 0000", k, g0, g1); end
      ncmp++; if (v0 !== 1'b1 || c0 !== 1'b0) begin nfail++; $display("FAIL idle_vc%0d got v=%b c=%b want v=1 c=0", k, v0, c0); end
    end
  endtask

  // Fresh reset so the counters start at zero; the 2-bit counter saturates along the way.
  task automatic test_rr_rotation();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    logic [1:0] exp_sat;
    rst = 1'b1; sel = 4'b0000;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sel = 4'b1111;
      for (int c = 0; c < 4; c++) d[c*8 +: 8] = 8'(8'hA0 + 16 * c + k);
      tick();
      exp_g   = 4'b0001 << (k % 4);
      exp_q   = 8'(8'hA0 + 16 * (k % 4) + k);
      exp_sat = (k >= 2) ? 2'd3 : 2'(k + 1);
      ncmp++; if (g1 !== exp_g) begin nfail++; $display("FAIL rr_g%0d got %b want %b", k, g1, exp_g); end
      ncmp++; if (q1 !== exp_q) begin nfail++; $display("FAIL rr_q%0d got %h want %h", k, q1, exp_q); end
      ncmp++; if (n1 !== 8'(k + 1)) begin nfail++; $display("FAIL rr_n%0d got %0d want %0d", k, n1, k + 1); end
      ncmp++; if (g0 !== 4'b1000 || q0 !== 8'(8'hD0 + k)) begin nfail++; $display("FAIL rr_fix%0d got g=%b q=%h want g=1000 q=%h", k, g0, q0, 8'(8'hD0 + k)); end
      ncmp++; if (n2 !== exp_sat) begin nfail++; $display("FAIL sat_n%0d got %0d want %0d", k, n2, exp_sat); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; sel = 4'b0001; d = 32'h0000_0042;
    tick();
    ncmp++; if (q1 !== 8'h42) begin nfail++; $display("FAIL mid_pre got %h want 42", q1); end
    rst = 1'b1; sel = 4'b0010; d = 32'h0000_FF00;
    tick();
    ncmp++; if (q0 !== 8'h00 || q1 !== 8'h00) begin nfail++; $display("FAIL mid_q got %h/%h want 00", q0, q1); end
    ncmp++; if (v0 !== 1'b0 || v1 !== 1'b0) begin nfail++; $display("FAIL mid_v got %b/%b want 0", v0, v1); end
    ncmp++; if (g0 !== 4'b0000 || g1 !== 4'b0000) begin nfail++; $display("FAIL mid_g got %b/%b want 0000", g0, g1); end
    ncmp++; if (n1 !== 8'd0) begin nfail++; $display("FAIL mid_n got %0d want 0", n1); end
    rst = 1'b0; sel = 4'b1111; d = 32'h44_33_22_11;
    tick();
    ncmp++; if (g1 !== 4'b0001 || q1 !== 8'h11) begin nfail++; $display("FAIL mid_ptr got g=%b q=%h want g=0001 q=11", g1, q1); end
  endtask

  // rr pointer starts at 1 (channel 0 just won).
  task automatic test_back_to_back();
    logic [3:0] sel_v [4] = '{4'b0101, 4'b0011, 4'b1000, 4'b0110};
    logic [3:0] g0_v  [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0100};
    logic [3:0] g1_v  [4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    logic       c_v   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      sel = sel_v[k]; d = 32'hF3_E2_D1_C0 + 32'h0101_0101 * k;
      tick();
      ncmp++; if (g0 !== g0_v[k]) begin nfail++; $display("FAIL b2b_fix%0d got %b want %b", k, g0, g0_v[k]); end
      ncmp++; if (g1 !== g1_v[k]) begin nfail++; $display("FAIL b2b_rr%0d got %b want %b", k, g1, g1_v[k]); end
      ncmp++; if (c0 !== c_v[k] || c1 !== c_v[k]) begin nfail++; $display("FAIL b2b_c%0d got %b/%b want %b", k, c0, c1, c_v[k]); end
    end
    sel = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_out_of_reset();
    test_fixed_conflict();
    test_idle_hold();
    test_rr_rotation();
    test_reset_mid();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
